path_reader: RTL and testbench
==============================

Name: path_reader

Overview:
- Reads back the predecessor table written during the Dijkstra relaxation phase.
- Walks from a destination node to the source, one node per handshake, and emits the shortest path in reverse order (destination first) over a valid/ready stream.
- Sits after the visited/predecessor store and consumes its flattened predecessor vector. Reports completion and error status.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES: number of entries in the predecessor vector.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH: width of a node index.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a walk; sampled only in IDLE.
- source  input  INDEX_WIDTH  path source node; captured on start.
- destination  input  INDEX_WIDTH  path end node; captured on start.
- number_of_nodes  input  INDEX_WIDTH  node count; captured on start; also the loop bound.
- prev_vector_flattened  input  INDEX_WIDTH*MAX_NODES  predecessor of node j in bits [INDEX_WIDTH*j +: INDEX_WIDTH]. Caller holds it stable while busy.
- path_node  output  INDEX_WIDTH  current path node.
- path_valid  output  1  path_node is valid.
- path_ready  input  1  consumer accepts path_node.
- path_last  output  1  qualifies path_node as the source (final node).
- busy  output  1  walk in progress (state != IDLE).
- done  output  1  one-cycle pulse when a walk ends, for any reason.
- path_length  output  INDEX_WIDTH  number of nodes accepted in the current/last walk.
- unreachable  output  1  status: predecessor UNVISITED before reaching source.
- loop_error  output  1  status: node count bound exceeded.
- bad_index  output  1  status: node index >= captured number_of_nodes.

Behaviour:
- Reset (asynchronous, active-low, immediate abort from any state):
  - State goes to IDLE.
  - All outputs 0: path_node, path_valid, path_last, busy, done, path_length, all status bits.
  - No done pulse is generated for an aborted walk.
- IDLE:
  - start=1 at edge N: capture source, destination and number_of_nodes; cur=destination; path_length=0; clear all status bits; go to CHECK.
  - busy is high from edge N.
- CHECK (one cycle, evaluates cur):
  - If cur >= number_of_nodes: bad_index=1, go to DONE.
  - Else if cur == source: go to EMIT with path_last=1. The predecessor entry of the source is never read.
  - Else if prev[cur] == `UNVISITED: unreachable=1, go to DONE. cur is not emitted.
  - Else: go to EMIT with path_last=0.
- EMIT:
  - path_valid=1, path_node=cur.
  - path_node and path_last are held stable until the transfer (path_valid & path_ready at a rising edge).
  - On transfer: path_length += 1.
    - If path_last: go to DONE (success; all status bits 0).
    - Else if path_length+1 >= number_of_nodes (the length after increment has reached the bound): loop_error=1, go to DONE.
    - Else: cur = prev[cur], go to CHECK.
  - path_valid drops in the cycle after the transfer.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - Status bits and path_length hold until the next accepted start.
- Latency:
  - start at edge N gives first path_valid after edge N+2.
  - Transfer at edge M gives the next path_valid after edge M+2.
  - Final transfer at edge M gives done high after edge M+1.
- start while busy is ignored.
- path_ready while path_valid=0 is ignored.
- Maximum emitted nodes per walk = number_of_nodes.
- number_of_nodes=0: any destination yields bad_index, with no emission.

Decomposition:
- constants.v (shared) holds `UNVISITED, `DEFAULT_MAX_NODES and `DEFAULT_INDEX_WIDTH, plus new state encodings `PR_IDLE, `PR_CHECK, `PR_EMIT, `PR_DONE (2-bit).
- One sub-module, prev_vector_mux: combinational select of one INDEX_WIDTH entry from prev_vector_flattened by index. It is reusable by other consumers of the predecessor store.

Test Plan:
- nodes=5, src=0, dst=3, prev[3]=1, prev[1]=0, ready=1 -> emits 3,1,0; path_last only on 0; path_length=3; status all 0; one done pulse.
- src=dst=2, nodes=5 -> single node 2 with path_last=1, path_length=1, success; prev[2] value is irrelevant, including `UNVISITED.
- nodes=5, src=0, dst=4, prev[4]=`UNVISITED -> no path_valid; unreachable=1; path_length=0; done pulses 2 cycles after start.
- nodes=3, src=0, dst=1, prev[1]=2, prev[2]=1 -> emits 1,2,1, then loop_error=1, path_length=3, done.
- src=0, dst=3 as in the first test, ready held low 4 cycles on each node -> path_node/path_valid stable, no advance, identical output sequence; dst=9 with nodes=5 -> bad_index=1, no emission.
- Start a 3-node walk, assert reset low during the second EMIT -> all outputs 0 immediately, no done; start re-pulsed while busy in the next walk -> ignored, walk completes normally.

Source files
------------

// File: rtl/path_reader_pkg.sv
// Shared definitions for the shortest-path read-back logic: default sizing
// and the walker state encoding.
package path_reader_pkg;

  localparam int DEFAULT_MAX_NODES   = 16;
  localparam int DEFAULT_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    PR_IDLE  = 2'd0,
    PR_CHECK = 2'd1,
    PR_EMIT  = 2'd2,
    PR_DONE  = 2'd3
  } pr_state_e;

endpackage

// File: rtl/path_reader_prev_vector_mux.sv
// Combinational select of one predecessor entry from the flattened table.
// Indices beyond the table return zero.
module prev_vector_mux #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_flat_i,
  input  logic [INDEX_WIDTH-1:0]           index_i,
  output logic [INDEX_WIDTH-1:0]           entry_o
);

  always_comb begin
    entry_o = '0;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (index_i == INDEX_WIDTH'(j)) begin
        entry_o = prev_flat_i[INDEX_WIDTH*j +: INDEX_WIDTH];
      end
    end
  end

endmodule

// File: rtl/path_reader.sv
// Walks the predecessor table from destination back to source and streams
// the path (destination first) over a valid/ready handshake.
import path_reader_pkg::*;

module path_reader #(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [INDEX_WIDTH-1:0]          source,
  input  logic [INDEX_WIDTH-1:0]          destination,
  input  logic [INDEX_WIDTH-1:0]          number_of_nodes,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  output logic [INDEX_WIDTH-1:0]          path_node,
  output logic                            path_valid,
  input  logic                            path_ready,
  output logic                            path_last,
  output logic                            busy,
  output logic                            done,
  output logic [INDEX_WIDTH-1:0]          path_length,
  output logic                            unreachable,
  output logic                            loop_error,
  output logic                            bad_index
);

  // The predecessor store marks never-reached nodes with an all-ones index.
  localparam logic [INDEX_WIDTH-1:0] UNVISITED = '1;

  pr_state_e              state_q;
  logic [INDEX_WIDTH-1:0] cur_q, src_q, nodes_q, len_q;
  logic                   valid_q, last_q, done_q;
  logic                   unreach_q, loop_q, bad_q;
  logic [INDEX_WIDTH-1:0] prev_d, len_d;

  prev_vector_mux #(
    .MAX_NODES  (MAX_NODES),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_prev_mux (
    .prev_flat_i(prev_vector_flattened),
    .index_i    (cur_q),
    .entry_o    (prev_d)
  );

  assign len_d = len_q + INDEX_WIDTH'(1);

  // path_valid rises one cycle after entering EMIT so each node costs two
  // cycles (CHECK plus the registered valid) before it is offered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= PR_IDLE;
      cur_q     <= '0;
      src_q     <= '0;
      nodes_q   <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      unreach_q <= 1'b0;
      loop_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PR_IDLE: begin
          if (start) begin
            src_q     <= source;
            nodes_q   <= number_of_nodes;
            cur_q     <= destination;
            len_q     <= '0;
            last_q    <= 1'b0;
            unreach_q <= 1'b0;
            loop_q    <= 1'b0;
            bad_q     <= 1'b0;
            state_q   <= PR_CHECK;
          end
        end
        PR_CHECK: begin
          if (cur_q >= nodes_q) begin
            bad_q   <= 1'b1;
            state_q <= PR_DONE;
          end else if (cur_q == src_q) begin
            last_q  <= 1'b1;
            state_q <= PR_EMIT;
          end else if (prev_d == UNVISITED) begin
            unreach_q <= 1'b1;
            state_q   <= PR_DONE;
          end else begin
            last_q  <= 1'b0;
            state_q <= PR_EMIT;
          end
        end
        PR_EMIT: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (path_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            len_q   <= len_d;
            if (last_q) begin
              state_q <= PR_DONE;
            end else if (len_d >= nodes_q) begin
              loop_q  <= 1'b1;
              state_q <= PR_DONE;
            end else begin
              cur_q   <= prev_d;
              state_q <= PR_CHECK;
            end
          end
        end
        PR_DONE: begin
          done_q  <= 1'b1;
          state_q <= PR_IDLE;
        end
        default: state_q <= PR_IDLE;
      endcase
    end
  end

  assign path_node   = cur_q;
  assign path_valid  = valid_q;
  assign path_last   = last_q;
  assign busy        = (state_q != PR_IDLE);
  assign done        = done_q;
  assign path_length = len_q;
  assign unreachable = unreach_q;
  assign loop_error  = loop_q;
  assign bad_index   = bad_q;

endmodule

// File: tb/tb_path_reader.sv
// Directed bench for path_reader: walks, stalls, error cases and reset abort.
module tb_path_reader;

  localparam int N = 16;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   source = '0, destination = '0, number_of_nodes = '0;
  logic [W*N-1:0] prevVec = '1;
  logic [W-1:0]   path_node;
  logic           path_valid, path_ready = 1'b0, path_last;
  logic           busy, done;
  logic [W-1:0]   path_length;
  logic           unreachable, loop_error, bad_index;

  int testsRun = 0;
  int testsFailed = 0;

  int nodesOut[$];
  int lastOut[$];
  int firstValidK, doneK, lastXferK;

  path_reader #(.MAX_NODES(N), .INDEX_WIDTH(W)) dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .source               (source),
    .destination          (destination),
    .number_of_nodes      (number_of_nodes),
    .prev_vector_flattened(prevVec),
    .path_node            (path_node),
    .path_valid           (path_valid),
    .path_ready           (path_ready),
    .path_last            (path_last),
    .busy                 (busy),
    .done                 (done),
    .path_length          (path_length),
    .unreachable          (unreachable),
    .loop_error           (loop_error),
    .bad_index            (bad_index)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setPrev(input int node, input int pred);
    prevVec[W*node +: W] = W'(pred);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_node"},  path_node, 0);
    checkOutput({tag, "_valid"}, path_valid, 0);
    checkOutput({tag, "_last"},  path_last, 0);
    checkOutput({tag, "_busy"},  busy, 0);
    checkOutput({tag, "_done"},  done, 0);
    checkOutput({tag, "_len"},   path_length, 0);
    checkOutput({tag, "_status"}, {unreachable, loop_error, bad_index}, 0);
  endtask

  // Starts a walk and consumes the stream; ready is withheld for 'stall'
  // cycles on each node. Inputs are scrambled after start to prove capture.
  task automatic applyStimulus(input int s, input int d, input int n, input int stall, input bit repulse);
    int holdCnt = 0;
    logic [W-1:0] heldNode = '0;
    logic heldLast = 1'b0;
    nodesOut.delete();
    lastOut.delete();
    firstValidK = -1; doneK = -1; lastXferK = -1;
    @(negedge clock);
    source = W'(s); destination = W'(d); number_of_nodes = W'(n);
    start = 1'b1; path_ready = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
    source = 4'd6; destination = 4'd7; number_of_nodes = 4'd15;
    checkOutput("busy_after_start", busy, 1);
    for (int k = 1; k <= 300 && doneK < 0; k++) begin
      @(negedge clock);
      start = (repulse && k == 2);
      if (done) doneK = k;
      if (path_valid) begin
        if (firstValidK < 0) firstValidK = k;
        if (holdCnt == 0) begin
          heldNode = path_node;
          heldLast = path_last;
        end else begin
          checkOutput("hold_node", path_node, heldNode);
          checkOutput("hold_last", path_last, heldLast);
        end
        if (holdCnt >= stall) begin
          path_ready = 1'b1;
          nodesOut.push_back(int'(path_node));
          lastOut.push_back(int'(path_last));
          lastXferK = k;
          holdCnt = 0;
        end else begin
          path_ready = 1'b0;
          holdCnt++;
        end
      end else begin
        path_ready = (stall == 0);
      end
    end
    start = 1'b0;
    path_ready = 1'b0;
    if (doneK < 0) checkOutput("done_timeout", 0, 1);
    @(negedge clock);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
  endtask

  task automatic checkWalk(input string tag, input int expCnt, input int n0, input int n1, input int n2,
                           input int l0, input int l1, input int l2, input logic [2:0] status, input int len);
    int expN[3];
    int expL[3];
    expN = '{n0, n1, n2};
    expL = '{l0, l1, l2};
    checkOutput({tag, "_count"}, nodesOut.size(), expCnt);
    for (int i = 0; i < expCnt && i < nodesOut.size(); i++) begin
      checkOutput($sformatf("%s_node%0d", tag, i), nodesOut[i], expN[i]);
      checkOutput($sformatf("%s_last%0d", tag, i), lastOut[i], expL[i]);
    end
    checkOutput({tag, "_len"}, path_length, len);
    checkOutput({tag, "_status"}, {unreachable, loop_error, bad_index}, status);
    if (expCnt > 0) begin
      checkOutput({tag, "_first_valid_lat"}, firstValidK, 3);
      checkOutput({tag, "_done_lat"}, doneK - lastXferK, 2);
    end else begin
      checkOutput({tag, "_no_valid"}, firstValidK, -1);
      checkOutput({tag, "_done_lat"}, doneK, 3);
    end
  endtask

  task automatic loadChain();
    prevVec = '1;
    setPrev(3, 1);
    setPrev(1, 0);
  endtask

  initial begin
    int vcount;
    #3;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b1;

    loadChain();
    applyStimulus(0, 3, 5, 0, 1'b0);
    checkWalk("chain", 3, 3, 1, 0, 0, 0, 1, 3'b000, 3);

    prevVec = '1;
    applyStimulus(2, 2, 5, 0, 1'b0);
    checkWalk("self", 1, 2, 0, 0, 1, 0, 0, 3'b000, 1);

    prevVec = '1;
    applyStimulus(0, 4, 5, 0, 1'b0);
    checkWalk("unreach", 0, 0, 0, 0, 0, 0, 0, 3'b100, 0);

    prevVec = '1;
    setPrev(1, 2);
    setPrev(2, 1);
    applyStimulus(0, 1, 3, 0, 1'b0);
    checkWalk("loop", 3, 1, 2, 1, 0, 0, 0, 3'b010, 3);

    loadChain();
    applyStimulus(0, 3, 5, 4, 1'b0);
    checkWalk("stall", 3, 3, 1, 0, 0, 0, 1, 3'b000, 3);

    applyStimulus(0, 9, 5, 0, 1'b0);
    checkWalk("badidx", 0, 0, 0, 0, 0, 0, 0, 3'b001, 0);

    applyStimulus(0, 0, 0, 0, 1'b0);
    checkWalk("zeronodes", 0, 0, 0, 0, 0, 0, 0, 3'b001, 0);

    // Abort the chain walk while its second node is being offered.
    loadChain();
    @(negedge clock);
    source = 4'd0; destination = 4'd3; number_of_nodes = 4'd5;
    start = 1'b1; path_ready = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    vcount = 0;
    for (int k = 0; k < 50 && vcount < 2; k++) begin
      @(negedge clock);
      if (path_valid) vcount++;
    end
    checkOutput("abort_second_emit_seen", vcount, 2);
    #2 reset = 1'b0;
    #1 checkAllZero("abort");
    path_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("abort_no_done", done, 0);
    end
    reset = 1'b1;

    applyStimulus(0, 3, 5, 0, 1'b1);
    checkWalk("repulse", 3, 3, 1, 0, 0, 0, 1, 3'b000, 3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
